seq_left_shift: RTL and testbench
=================================

Name: seq_left_shift

Overview:
Multi-cycle 32-bit left shifter for the processor's SLL path. It mirrors the fixed arithmetic right-shift stages in the opposite direction: one shift stage per cycle (16, 8, 4, 2, 1), applied only when the matching shamt bit is set. It also reports signed overflow, so the ALU can raise an exception on arithmetic left shifts. A start/ready/valid handshake lets the execute stage stall while the shift is in flight.

Parameters:
WIDTH, 32, data width; fixed at 32 for this processor.
SHW, 5, shift-amount width (log2 WIDTH).

Ports:
clock  input  1  system clock, rising-edge.
reset_n  input  1  asynchronous active-low reset.
start  input  1  request; accepted only when ready=1.
data_in  input  32  operand, sampled on the accepted start.
shamt  input  5  shift amount 0..31, sampled on the accepted start.
ready  output  1  high in IDLE only.
result  output  32  shifted value; held until the next accepted start.
result_valid  output  1  one-cycle pulse when result and ovf are final.
ovf  output  1  signed overflow of the left shift; valid with result_valid and held afterwards.

Behaviour:
- Reset (async, reset_n=0): state=IDLE, ready=1, result=0, result_valid=0, ovf=0, stage counter=0. This applies immediately, including mid-operation; the in-flight shift is discarded with no result_valid pulse.
- States: IDLE, SHIFT, DONE.
- IDLE:
  - ready=1.
  - On start=1 at rising edge T: latch data_in into the working register and shamt into the amount register, clear ovf, set stage=0, go to SHIFT.
  - start=0: remain in IDLE.
- SHIFT:
  - ready=0. One stage per edge, in order T+1..T+5: amounts 16, 8, 4, 2, 1.
  - Stage k uses amount s = 16>>k. If amount-register bit (4-k) is set:
    - working <= working << s, zero fill.
    - ovf <= ovf | (working[31:31-s] not all equal), evaluated on the pre-shift value.
  - If the bit is clear, working and ovf are unchanged.
  - After stage 4 (edge T+5), go to DONE.
- DONE:
  - result_valid=1 for exactly one cycle, the cycle after edge T+5.
  - result equals the working register; the output is driven directly from it.
  - Next edge returns to IDLE.
- Latency: fixed 6 edges from the accepted start to IDLE, independent of shamt. shamt=0 still takes the full sequence.
- start while ready=0 (SHIFT or DONE) is ignored. It is not queued, and data_in/shamt changes have no effect.
- start held high continuously: a new operation is accepted on each return to IDLE, giving a throughput of one operation per 7 cycles.
- Overflow definition: ovf=1 iff the top shamt+1 bits of the original data_in are not all equal, i.e. the result differs from the true signed product data_in*2^shamt. The stagewise accumulation above is exactly equivalent.
- ovf is informational only; result is always the logical left shift.
- result and ovf hold their values through IDLE until the next accepted start. On acceptance, ovf clears and result tracks the working register.

Test Plan:
- Basic shift: reset, then start with data_in=0x0000_0001, shamt=4 -> ready drops the next cycle; result_valid pulses exactly 6 cycles after start; result=0x0000_0010, ovf=0.
- Overflow into sign bit: data_in=0x4000_0000, shamt=1 -> result=0x8000_0000, ovf=1. Then data_in=0x1234_5678, shamt=8 -> result=0x3456_7800, ovf=1.
- No overflow on negatives: data_in=0xFFFF_FFFF, shamt=31 -> result=0x8000_0000, ovf=0. Then data_in=0xFFFF_FFF0, shamt=27 -> result=0x8000_0000, ovf=0.
- Zero and all-stage amounts: shamt=0, data_in=0xDEAD_BEEF -> result=0xDEAD_BEEF, ovf=0, same 6-cycle latency. Then shamt=31 with data_in=0x0000_0001 -> result=0x8000_0000, ovf=1.
- Busy and back-to-back starts:
  - A start pulse during SHIFT carrying different data_in/shamt is ignored; the first result is unaffected.
  - start held high gives consecutive results 7 cycles apart.
  - result stays stable between result_valid pulses.
- Reset mid-operation: assert reset_n=0 two cycles after start -> ready=1, result=0, ovf=0 immediately (asynchronous); no result_valid follows. After release, a fresh operation completes correctly.

Source files
------------

// File: rtl/seq_left_shift.sv
// Multi-cycle 32-bit left shifter: one binary-weighted stage per cycle (16,8,4,2,1)
// with signed-overflow accumulation and a start/ready/result_valid handshake.
module seq_left_shift #(
  parameter int WIDTH = 32,
  parameter int SHW   = 5
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             start,
  input  logic [WIDTH-1:0] data_in,
  input  logic [SHW-1:0]   shamt,
  output logic             ready,
  output logic [WIDTH-1:0] result,
  output logic             result_valid,
  output logic             ovf
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [2:0]       stage_q, stage_d;
  logic [WIDTH-1:0] work_q, work_d;
  logic [SHW-1:0]   amt_q, amt_d;
  logic             ovf_q, ovf_d;
  logic             ready_q, ready_d;
  logic             valid_q, valid_d;

  logic [SHW-1:0]   step_s;
  logic [2:0]       bit_idx_s;

  // A shift by s keeps the signed value only if the top s+1 bits are all equal.
  function automatic logic top_bits_uniform(input logic [WIDTH-1:0] w,
                                            input logic [SHW-1:0]   s);
    logic [WIDTH-1:0] m;
    m = {WIDTH{1'b1}} << (5'd31 - s);
    return ((w & m) == {WIDTH{1'b0}}) || ((w & m) == m);
  endfunction

  // Stage weight and the amount-register bit that enables it.
  always_comb begin
    step_s    = 5'd16 >> stage_q;
    bit_idx_s = 3'd4 - stage_q;
  end

  // Next-state, datapath and handshake decode.
  always_comb begin
    state_d = state_q;
    stage_d = stage_q;
    work_d  = work_q;
    amt_d   = amt_q;
    ovf_d   = ovf_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          work_d  = data_in;
          amt_d   = shamt;
          ovf_d   = 1'b0;
          stage_d = 3'd0;
          state_d = SHIFT;
        end else begin
          state_d = IDLE;
        end
      end
      SHIFT: begin
        if (amt_q[bit_idx_s]) begin
          work_d = work_q << step_s;
          ovf_d  = ovf_q | ~top_bits_uniform(work_q, step_s);
        end else begin
          work_d = work_q;
          ovf_d  = ovf_q;
        end
        if (stage_q == 3'd4) begin
          stage_d = 3'd0;
          state_d = DONE;
        end else begin
          stage_d = stage_q + 3'd1;
          state_d = SHIFT;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        stage_d = 3'd0;
      end
    endcase
    ready_d = (state_d == IDLE);
    valid_d = (state_d == DONE);
  end

  // State and datapath registers; reset discards any in-flight shift.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      stage_q <= 3'd0;
      work_q  <= {WIDTH{1'b0}};
      amt_q   <= {SHW{1'b0}};
      ovf_q   <= 1'b0;
      ready_q <= 1'b1;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      stage_q <= stage_d;
      work_q  <= work_d;
      amt_q   <= amt_d;
      ovf_q   <= ovf_d;
      ready_q <= ready_d;
      valid_q <= valid_d;
    end
  end

  assign ready        = ready_q;
  assign result       = work_q;
  assign result_valid = valid_q;
  assign ovf          = ovf_q;

endmodule

// File: tb/tb_seq_left_shift.sv
// Self-checking bench for seq_left_shift: directed table, corner sequences and
// randomized operations against an arithmetic reference model.
module tb_seq_left_shift;

  logic        clock;
  logic        reset_n;
  logic        start;
  logic [31:0] data_in;
  logic [4:0]  shamt;
  logic        ready;
  logic [31:0] result;
  logic        result_valid;
  logic        ovf;

  int errors = 0;
  int checks = 0;

  seq_left_shift dut (
    .clock        (clock),
    .reset_n      (reset_n),
    .start        (start),
    .data_in      (data_in),
    .shamt        (shamt),
    .ready        (ready),
    .result       (result),
    .result_valid (result_valid),
    .ovf          (ovf)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic [31:0] d;
    logic [4:0]  sh;
    logic [31:0] exp_res;
    logic        exp_ovf;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Reference: logical shift; overflow iff the signed value is not recovered by
  // shifting back arithmetically (result != data_in * 2^shamt).
  function automatic logic [31:0] ref_res(input logic [31:0] d, input logic [4:0] sh);
    return d << sh;
  endfunction

  function automatic logic ref_ovf(input logic [31:0] d, input logic [4:0] sh);
    logic signed [31:0] r;
    r = $signed(d << sh);
    return (r >>> sh) != $signed(d);
  endfunction

  // One complete operation, checking handshake timing, outputs and hold.
  task automatic do_op(input logic [31:0] d, input logic [4:0] sh,
                       input logic [31:0] er, input logic eo, input string name);
    int cyc;
    logic [31:0] held;
    @(negedge clock);
    check({name, "_ready_idle"}, {31'd0, ready}, 32'd1);
    start = 1'b1; data_in = d; shamt = sh;
    @(posedge clock);
    @(negedge clock);
    start = 1'b0; data_in = ~d; shamt = ~sh;
    check({name, "_ready_drop"}, {31'd0, ready}, 32'd0);
    cyc = 1;
    while (!result_valid && cyc < 20) begin
      @(negedge clock);
      cyc++;
    end
    check({name, "_latency"}, cyc, 32'd6);
    check({name, "_result"}, result, er);
    check({name, "_ovf"}, {31'd0, ovf}, {31'd0, eo});
    held = result;
    @(negedge clock);
    check({name, "_pulse_end"}, {31'd0, result_valid}, 32'd0);
    check({name, "_ready_back"}, {31'd0, ready}, 32'd1);
    @(negedge clock);
    check({name, "_hold_res"}, result, held);
    check({name, "_hold_ovf"}, {31'd0, ovf}, {31'd0, eo});
  endtask

  initial begin
    vec_t vecs[8];
    int   pulses[$];
    logic [31:0] d;
    logic [4:0]  sh;
    logic [31:0] first_res;
    int   seen;

    vecs[0] = '{32'h0000_0001, 5'd4,  32'h0000_0010, 1'b0};
    vecs[1] = '{32'h4000_0000, 5'd1,  32'h8000_0000, 1'b1};
    vecs[2] = '{32'h1234_5678, 5'd8,  32'h3456_7800, 1'b1};
    vecs[3] = '{32'hFFFF_FFFF, 5'd31, 32'h8000_0000, 1'b0};
    vecs[4] = '{32'hFFFF_FFF0, 5'd27, 32'h8000_0000, 1'b0};
    vecs[5] = '{32'hDEAD_BEEF, 5'd0,  32'hDEAD_BEEF, 1'b0};
    vecs[6] = '{32'h0000_0001, 5'd31, 32'h8000_0000, 1'b1};
    vecs[7] = '{32'hC000_0000, 5'd1,  32'h8000_0000, 1'b0};

    reset_n = 1'b0; start = 1'b0; data_in = 32'd0; shamt = 5'd0;
    #12;
    check("rst_ready", {31'd0, ready}, 32'd1);
    check("rst_result", result, 32'd0);
    check("rst_valid", {31'd0, result_valid}, 32'd0);
    check("rst_ovf", {31'd0, ovf}, 32'd0);
    @(negedge clock);
    reset_n = 1'b1;

    for (int i = 0; i < 8; i++)
      do_op(vecs[i].d, vecs[i].sh, vecs[i].exp_res, vecs[i].exp_ovf, $sformatf("vec%0d", i));

    // Start pulse during SHIFT with different operands must be ignored.
    @(negedge clock);
    start = 1'b1; data_in = 32'h0000_00FF; shamt = 5'd4;
    @(posedge clock);
    @(negedge clock);
    start = 1'b0;
    @(negedge clock);
    start = 1'b1; data_in = 32'h7FFF_FFFF; shamt = 5'd31;
    @(negedge clock);
    start = 1'b0;
    seen = 3;
    while (!result_valid && seen < 20) begin
      @(negedge clock);
      seen++;
    end
    check("busy_latency", seen, 32'd6);
    check("busy_result", result, 32'h0000_0FF0);
    check("busy_ovf", {31'd0, ovf}, 32'd0);
    repeat (2) @(negedge clock);

    // start held high: one result every 7 cycles.
    start = 1'b1; data_in = 32'h0000_0003; shamt = 5'd30;
    for (int c = 0; c < 16; c++) begin
      if (result_valid) begin
        pulses.push_back(c);
        check($sformatf("held_res%0d", c), result, 32'hC000_0000);
        check($sformatf("held_ovf%0d", c), {31'd0, ovf}, 32'd1);
      end
      if (c == 13) start = 1'b0;
      @(negedge clock);
    end
    check("held_pulses", pulses.size(), 32'd2);
    if (pulses.size() == 2) begin
      check("held_first", pulses[0], 32'd6);
      check("held_gap", pulses[1] - pulses[0], 32'd7);
    end
    repeat (3) @(negedge clock);

    // Asynchronous reset two cycles after acceptance.
    start = 1'b1; data_in = 32'h4000_0001; shamt = 5'd17;
    @(posedge clock);
    @(negedge clock);
    start = 1'b0;
    @(negedge clock);
    #2;
    reset_n = 1'b0;
    #1;
    check("mid_rst_ready", {31'd0, ready}, 32'd1);
    check("mid_rst_result", result, 32'd0);
    check("mid_rst_ovf", {31'd0, ovf}, 32'd0);
    @(negedge clock);
    reset_n = 1'b1;
    seen = 0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clock);
      if (result_valid) seen++;
    end
    check("mid_rst_no_valid", seen, 32'd0);
    do_op(32'h0000_0005, 5'd3, 32'h0000_0028, 1'b0, "post_rst");

    // Randomized operations against the reference model.
    for (int i = 0; i < 40; i++) begin
      d  = $urandom;
      sh = 5'($urandom_range(0, 31));
      if (i % 4 == 0) d = {{16{d[31]}}, d[15:0]};
      do_op(d, sh, ref_res(d, sh), ref_ovf(d, sh), $sformatf("rnd%0d", i));
    end

    first_res = result;
    repeat (5) @(negedge clock);
    check("idle_hold", result, first_res);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
